mem_ctrl: RTL

- Responder side of the mm↔mct memory-request interface. Serves the IF stage (instruction fetch) and the MM stage (load/store).
- Turns each word, half or byte request into byte-serial accesses on the 8-bit synchronous RAM port.
- Returns completion with a one-cycle ok pulse.
- Sits between the pipeline stages and the external byte-wide RAM/IO bus.

---
 rtl/mem_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: turns IF fetches and MM loads/stores into 8-bit RAM accesses.
// Optional MCT_IO_FULL_EN adds io_full back-pressure for stores into the IO window.
module mem_ctrl #(
  parameter int unsigned        ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(32'h0003_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_mct_e,
  input  logic [ADDR_W-1:0] if_mct_a,
  output logic              if_mct_ok,
  input  logic              mm_mct_e,
  input  logic [ADDR_W-1:0] mm_mct_a,
  input  logic              mm_mct_wr,
  input  logic [1:0]        mm_mct_cu,
  input  logic [31:0]       mm_mct_n_i,
  output logic              mm_mct_ok,
  output logic [31:0]       mm_mct_n_o,
`ifdef MCT_IO_FULL_EN
  input  logic              io_full,
`endif
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        rom_rn
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e            state_q;
  logic [1:0]        cnt_q;
  logic [1:0]        last_q;
  logic [ADDR_W-1:0] a_q;
  logic [31:0]       n_q;
  logic              owner_mm_q;

  logic [1:0]        cnt_nxt;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] addr_nxt;
  logic              blk_acc;
  logic              blk_cur;
  logic              blk_nxt;

  assign cnt_nxt  = cnt_q + 2'd1;
  assign lane     = cnt_q - 2'd1;
  assign addr_nxt = a_q + ADDR_W'(cnt_nxt);

`ifdef MCT_IO_FULL_EN
  // Stall a store byte headed into the IO window while the IO side is full
  assign blk_acc = io_full && (mm_mct_a >= IO_BASE);
  assign blk_cur = io_full && (ram_a >= IO_BASE);
  assign blk_nxt = io_full && (addr_nxt >= IO_BASE);
`else
  assign blk_acc = 1'b0;
  assign blk_cur = 1'b0;
  assign blk_nxt = 1'b0;
`endif

  // cu encodes byte count minus one; a count of three is rounded up to a full word
  function automatic logic [1:0] last_of(input logic [1:0] cu);
    logic [1:0] r;
    r = 2'd3;
    if (cu == 2'd0) r = 2'd0;
    else if (cu == 2'd1) r = 2'd1;
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= 2'd0;
      last_q     <= 2'd0;
      a_q        <= '0;
      n_q        <= '0;
      owner_mm_q <= 1'b0;
      ram_a      <= '0;
      ram_dout   <= '0;
      ram_wr     <= 1'b0;
      if_mct_ok  <= 1'b0;
      mm_mct_ok  <= 1'b0;
      mm_mct_n_o <= '0;
    end else begin
      if_mct_ok <= 1'b0;
      mm_mct_ok <= 1'b0;
      unique case (state_q)
        StIdle: begin
          ram_wr <= 1'b0;
          if (mm_mct_e) begin
            a_q        <= mm_mct_a;
            n_q        <= mm_mct_n_i;
            owner_mm_q <= 1'b1;
            last_q     <= last_of(mm_mct_cu);
            cnt_q      <= 2'd0;
            mm_mct_n_o <= '0;
            ram_a      <= mm_mct_a;
            if (mm_mct_wr) begin
              state_q  <= StWrite;
              ram_dout <= mm_mct_n_i[7:0];
              ram_wr   <= !blk_acc;
            end else begin
              state_q  <= StRead;
            end
          end else if (if_mct_e) begin
            a_q        <= if_mct_a;
            owner_mm_q <= 1'b0;
            last_q     <= 2'd3;
            cnt_q      <= 2'd0;
            mm_mct_n_o <= '0;
            ram_a      <= if_mct_a;
            state_q    <= StRead;
          end
        end
        StRead: begin
          // Byte for the previous address is on rom_rn now; the last one is left on the bus
          if (cnt_q != 2'd0) mm_mct_n_o[{lane, 3'b000} +: 8] <= rom_rn;
          if (!owner_mm_q && !if_mct_e) begin
            state_q <= StIdle;
          end else if (cnt_q == last_q) begin
            state_q <= StDone;
            if (owner_mm_q) mm_mct_ok <= 1'b1;
            else if_mct_ok <= 1'b1;
          end else begin
            cnt_q <= cnt_nxt;
            ram_a <= addr_nxt;
          end
        end
        StWrite: begin
          if (!ram_wr) begin
            ram_wr <= !blk_cur;
          end else if (cnt_q == last_q) begin
            ram_wr    <= 1'b0;
            state_q   <= StDone;
            mm_mct_ok <= 1'b1;
          end else begin
            cnt_q    <= cnt_nxt;
            ram_a    <= addr_nxt;
            ram_dout <= n_q[{cnt_nxt, 3'b000} +: 8];
            ram_wr   <= !blk_nxt;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
